// File: rtl/ex_mult.sv
// Iterative shift-add 32x32 multiplier for the EX stage: WIDTH add cycles on
// magnitudes, then a one-cycle DONE that applies the sign and strobes done.
module ex_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [4:0]       rd_d,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [4:0]       rd_q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   add_term;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH-1:0]     lo_hold, hi_hold;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [4:0]           rd_hold, rd_res;
  logic                 issue;
  logic                 last_iter;

  assign issue     = (state == IDLE) && start && !flush;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign abs_a     = (signed_op && opA[WIDTH-1]) ? -opA : opA;
  assign abs_b     = (signed_op && opB[WIDTH-1]) ? -opB : opB;
  assign add_term  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign result    = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      rd_res  <= '0;
      rd_hold <= '0;
      lo_hold <= '0;
      hi_hold <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (issue) begin
            mcand  <= abs_a;
            mplier <= abs_b;
            neg    <= signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            rd_res <= rd_d;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (!flush) begin
            acc    <= acc + add_term;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Latch the delivered result so it persists after the strobe.
          if (!flush) begin
            lo_hold <= result[WIDTH-1:0];
            hi_hold <= result[2*WIDTH-1:WIDTH];
            rd_hold <= rd_res;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign stall_req = issue || (state == RUN);
  assign done      = (state == DONE) && !flush;
  // A flush in DONE suppresses the strobe and leaves the old result visible.
  assign prod_lo   = done ? result[WIDTH-1:0]       : lo_hold;
  assign prod_hi   = done ? result[2*WIDTH-1:WIDTH] : hi_hold;
  assign rd_q      = done ? rd_res                  : rd_hold;

endmodule

// File: tb/tb_ex_mult.sv
// Scoreboard bench for ex_mult: expected products are computed with a plain
// 64-bit multiply when an operation is issued and popped when done strobes.
module tb_ex_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [4:0]  rd_d = '0;
  logic        busy, stall_req, done;
  logic [31:0] prod_lo, prod_hi;
  logic [4:0]  rd_q;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] prod;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ex_mult #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .flush(flush),
    .opA(opA), .opB(opB), .rd_d(rd_d), .busy(busy), .stall_req(stall_req),
    .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi), .rd_q(rd_q)
  );

  always #5 clk = ~clk;

  // Drives one issue cycle and pushes the expected result; returns in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [4:0] rd, output logic st);
    logic [63:0] ea, eb;
    exp_t e;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    e.rd = rd;
    e.prod = ea * eb;
    sb.push_back(e);
    start = 1'b1; opA = a; opB = b; signed_op = s; rd_d = rd;
    #1 st = stall_req;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles since the issue cycle.
  task automatic wait_done(output int lat, output int stalls);
    lat = 1; stalls = 0;
    while (!done && lat < 60) begin
      if (stall_req) stalls++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, stall_req, done} !== 3'b000 || prod_lo !== 0 || prod_hi !== 0 || rd_q !== 0) begin
      errors++;
      $display("FAIL reset_state: busy/stall/done=%b prod=%h_%h rd_q=%0d, need 000 0_0 0",
               {busy, stall_req, done}, prod_hi, prod_lo, rd_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic st; int lat, stl; exp_t e;
    issue(32'd7, 32'd6, 1'b0, 5'd5, st);
    wait_done(lat, stl);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL unsigned_latency: got %0d need 33", lat); end
    checks++;
    if (st + stl !== 33) begin errors++; $display("FAIL unsigned_stall_cycles: got %0d need 33", st + stl); end
    e = sb.pop_front();
    checks++;
    if ({prod_hi, prod_lo} !== e.prod || rd_q !== e.rd || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_result: got %h_%h rd %0d stall %b need %h rd %0d stall 0",
               prod_hi, prod_lo, rd_q, stall_req, e.prod, e.rd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || prod_lo !== 32'd42 || rd_q !== 5'd5) begin
      errors++;
      $display("FAIL unsigned_after_done: done %b busy %b prod_lo %0d rd %0d need 0 0 42 5",
               done, busy, prod_lo, rd_q);
    end
  endtask

  task automatic test_flush;
    logic st; int lat, stl; logic seen;
    issue(32'd3, 32'd4, 1'b0, 5'd7, st);
    sb.delete();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_run_idle: busy %b stall %b need 0 0", busy, stall_req);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || prod_lo !== 32'd42 || prod_hi !== 0 || rd_q !== 5'd5) begin
      errors++;
      $display("FAIL flush_run_hold: done_seen %b prod %h_%h rd %0d need 0 0_2a 5",
               seen, prod_hi, prod_lo, rd_q);
    end
    // Flush landing in the DONE cycle
    issue(32'd11, 32'd2, 1'b0, 5'd3, st);
    wait_done(lat, stl);
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || prod_lo !== 32'd42 || rd_q !== 5'd5) begin
      errors++;
      $display("FAIL flush_done_suppress: done %b prod_lo %0d rd %0d need 0 42 5", done, prod_lo, rd_q);
    end
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || prod_lo !== 32'd42) begin
      errors++; $display("FAIL flush_done_after: busy %b prod_lo %0d need 0 42", busy, prod_lo);
    end
    // Flush and start together in IDLE
    start = 1'b1; flush = 1'b1; opA = 32'd5; opB = 32'd5;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b need 0", stall_req); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b need 0", busy); end
  endtask

  task automatic test_ops(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [4:0] rd);
    logic st; int lat, stl; exp_t e;
    issue(a, b, s, rd, st);
    wait_done(lat, stl);
    e = sb.pop_front();
    checks++;
    if (lat !== 33 || {prod_hi, prod_lo} !== e.prod || rd_q !== e.rd) begin
      errors++;
      $display("FAIL op_%h_x_%h_s%0d: lat %0d got %h_%h rd %0d need lat 33 %h rd %0d",
               a, b, s, lat, prod_hi, prod_lo, rd_q, e.prod, e.rd);
    end
    @(negedge clk);
  endtask

  task automatic test_signed;
    test_ops(32'hFFFF_FFFD, 32'd5, 1'b1, 5'd1);
    test_ops(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd2);
    test_ops(32'd0, 32'hDEAD_BEEF, 1'b1, 5'd3);
  endtask

  task automatic test_extreme;
    test_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd30);
    test_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd31);
    test_ops(32'h1234_5678, 32'd0, 1'b0, 5'd4);
  endtask

  task automatic test_back_to_back;
    logic st; int lat, stl; exp_t e;
    issue(32'd100, 32'd3, 1'b0, 5'd9, st);
    start = 1'b1; opA = 32'd9; opB = 32'd9; signed_op = 1'b0; rd_d = 5'd12;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_done(lat, stl);
    e = sb.pop_front();
    checks++;
    if (lat + 10 !== 33 || {prod_hi, prod_lo} !== e.prod || rd_q !== e.rd) begin
      errors++;
      $display("FAIL illegal_start: lat %0d got %h_%h rd %0d need 33 %h rd %0d",
               lat + 10, prod_hi, prod_lo, rd_q, e.prod, e.rd);
    end
    @(negedge clk);
    issue(32'd9, 32'd9, 1'b0, 5'd12, st);
    wait_done(lat, stl);
    e = sb.pop_front();
    checks++;
    if (lat !== 33 || {prod_hi, prod_lo} !== e.prod || prod_lo !== 32'd81 || rd_q !== 5'd12) begin
      errors++;
      $display("FAIL back_to_back: lat %0d got %h_%h rd %0d need 33 %h rd 12",
               lat, prod_hi, prod_lo, rd_q, e.prod);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic st;
    issue(32'd5, 32'd5, 1'b0, 5'd4, st);
    repeat (14) @(negedge clk);
    rst = 1'b1; start = 1'b1; opA = 32'd2; opB = 32'd2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b need 0", busy); end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0 ||
        prod_lo !== 0 || prod_hi !== 0 || rd_q !== 0) begin
      errors++;
      $display("FAIL reset_mid_state: busy %b stall %b done %b prod %h_%h rd %0d need all 0",
               busy, stall_req, done, prod_hi, prod_lo, rd_q);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++)
      test_ops($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_unsigned;
    test_flush;
    test_signed;
    test_extreme;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
